shift_out_stage: RTL and testbench



---
 rtl/shift_out_stage.sv | 139 +++++++++++++
 tb/tb_shift_out_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_out_stage.sv
// shift_out_stage
// Registered output stage behind the 16-bit combinational shift_right unit.
// Captures one shifter transaction per cycle, derives status flags at accept
// time, buffers results in a 2-entry skid buffer (main + skid register) and
// hands them downstream over a valid/ready handshake.
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-high
//   in_valid   upstream transaction present
//   in_ready   stage can accept (registered, never a function of out_ready)
//   s          shift amount applied to shift_right
//   d_in       operand fed to shift_right
//   d_out      shift_right result (d_in >> s, logical)
//   out_valid  res/flags hold a valid result
//   out_ready  downstream accepts this cycle
//   res        registered shift result
//   flag_z     res == 0
//   flag_n     res[W-1]
//   flag_c     last bit shifted out (d_in[s-1], 0 when s == 0)
//   out_count  output handshakes since reset, modulo 2^CW
module shift_out_stage #(
   parameter int W  = 16,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    s,
   input  logic [W-1:0]  d_in,
   input  logic [W-1:0]  d_out,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  res,
   output logic          flag_z,
   output logic          flag_n,
   output logic          flag_c,
   output logic [CW-1:0] out_count
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t         state;
   logic [W-1:0]   skid_res_p1;
   logic           skid_z_p1;
   logic           skid_n_p1;
   logic           skid_c_p1;

   logic           accept;
   logic           transfer;
   logic           new_z_p0;
   logic           new_n_p0;
   logic           new_c_p0;

   // The carry is the bit that fell off the bottom of the operand, which only
   // the unshifted operand still holds.
   function automatic logic carry_out(input logic [3:0] amt,
                                      input logic [W-1:0] opnd);
      if (amt == 4'd0) return 1'b0;
      return opnd[amt - 4'd1];
   endfunction

   // Stage p0: flags derived from the live shifter inputs at accept time
   assign accept   = in_valid && in_ready;
   assign transfer = out_valid && out_ready;
   assign new_z_p0 = (d_out == '0);
   assign new_n_p0 = d_out[W-1];
   assign new_c_p0 = carry_out(s, d_in);

   // Stage p1: main/skid registers, occupancy FSM and delivery counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= EMPTY;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         res         <= '0;
         flag_z      <= 1'b0;
         flag_n      <= 1'b0;
         flag_c      <= 1'b0;
         skid_res_p1 <= '0;
         skid_z_p1   <= 1'b0;
         skid_n_p1   <= 1'b0;
         skid_c_p1   <= 1'b0;
         out_count   <= '0;
      end else begin
         if (transfer) out_count <= out_count + CW'(1);

         case (state)
            EMPTY: begin
               if (accept) begin
                  res       <= d_out;
                  flag_z    <= new_z_p0;
                  flag_n    <= new_n_p0;
                  flag_c    <= new_c_p0;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (accept && !transfer) begin
                  // Downstream stalled: park the newcomer behind the head.
                  skid_res_p1 <= d_out;
                  skid_z_p1   <= new_z_p0;
                  skid_n_p1   <= new_n_p0;
                  skid_c_p1   <= new_c_p0;
                  in_ready    <= 1'b0;
                  state       <= FULL;
               end else if (accept && transfer) begin
                  res    <= d_out;
                  flag_z <= new_z_p0;
                  flag_n <= new_n_p0;
                  flag_c <= new_c_p0;
               end else if (transfer) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so no accept can coincide.
               if (transfer) begin
                  res      <= skid_res_p1;
                  flag_z   <= skid_z_p1;
                  flag_n   <= skid_n_p1;
                  flag_c   <= skid_c_p1;
                  in_ready <= 1'b1;
                  state    <= ONE;
               end
            end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_out_stage.sv
// Testbench for shift_out_stage: randomized and directed stimulus checked
// against a queue-based reference of the stage's buffering behaviour.
module tb_shift_out_stage;
   localparam int W  = 16;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    s;
   logic [W-1:0]  d_in;
   logic [W-1:0]  d_out;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  res;
   logic          flag_z;
   logic          flag_n;
   logic          flag_c;
   logic [CW-1:0] out_count;

   int checks = 0;
   int passed = 0;

   // Reference item: {c, n, z, res}
   typedef logic [W+2:0] item_t;
   item_t         q[$];
   logic [CW-1:0] m_cnt = '0;

   always #5 clk = ~clk;

   shift_out_stage #(.W(W), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .s(s), .d_in(d_in), .d_out(d_out),
      .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
      .out_count(out_count)
   );

   function automatic item_t ref_item(input logic [3:0] sv, input logic [W-1:0] dv);
      logic [W-1:0] r;
      logic [W-1:0] t;
      logic c;
      r = dv >> sv;
      t = dv >> (sv - 4'd1);
      c = (sv == 4'd0) ? 1'b0 : t[0];
      return {c, r[W-1], (r == '0), r};
   endfunction

   // Drive one cycle and advance the reference: a stage holding up to two
   // results in FIFO order, ready whenever it holds fewer than two.
   task automatic step(input logic rst, input logic iv, input logic [3:0] sv,
                       input logic [W-1:0] dv, input logic ordy);
      bit m_valid;
      bit m_ready;
      m_valid   = (q.size() > 0);
      m_ready   = (q.size() < 2);
      reset     = rst;
      in_valid  = iv;
      s         = sv;
      d_in      = dv;
      d_out     = dv >> sv;
      out_ready = ordy;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_cnt = '0;
      end else begin
         if (m_valid && ordy) begin
            void'(q.pop_front());
            m_cnt = m_cnt + 1'b1;
         end
         if (iv && m_ready) q.push_back(ref_item(sv, dv));
      end
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 4'd3, 16'hFFFF, 1'b1);
      step(1'b1, 1'b1, 4'd5, 16'h1234, 1'b0);
      checks++;
      if ({out_valid, in_ready, res, flag_z, flag_n, flag_c, out_count} !==
          {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00})
         $display("FAIL reset_state: got v=%0b r=%0b res=%h z%0b n%0b c%0b cnt=%0d, need v=0 r=1 res=0000 flags 0 cnt=0",
                  out_valid, in_ready, res, flag_z, flag_n, flag_c, out_count);
      else passed++;
   endtask

   task automatic test_basic();
      step(1'b0, 1'b1, 4'd4, 16'hCDEF, 1'b1);
      checks++;
      if ({out_valid, res, flag_c, flag_z, flag_n} !== {1'b1, 16'h0CDE, 1'b1, 1'b0, 1'b0})
         $display("FAIL basic_result: got v=%0b res=%h c%0b z%0b n%0b, need v=1 res=0cde c1 z0 n0",
                  out_valid, res, flag_c, flag_z, flag_n);
      else passed++;
      step(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
      checks++;
      if ({out_valid, out_count} !== {1'b0, 8'd1})
         $display("FAIL basic_count: got v=%0b cnt=%0d, need v=0 cnt=1", out_valid, out_count);
      else passed++;
   endtask

   task automatic test_sweep();
      step(1'b1, 1'b0, 4'd0, 16'h0000, 1'b0);
      for (int k = 0; k < 16; k++) begin
         step(1'b0, 1'b1, 4'(k), 16'hCDEF, 1'b1);
         checks++;
         if ({out_valid, in_ready, out_count} !== {(q.size() > 0), (q.size() < 2), m_cnt})
            $display("FAIL sweep_ctrl s=%0d: got v=%0b r=%0b cnt=%0d, need v=%0b r=%0b cnt=%0d",
                     k, out_valid, in_ready, out_count, q.size() > 0, q.size() < 2, m_cnt);
         else passed++;
         checks++;
         if (q.size() == 0 || {flag_c, flag_n, flag_z, res} !== q[0])
            $display("FAIL sweep_data s=%0d: got c%0b n%0b z%0b res=%h, need %h",
                     k, flag_c, flag_n, flag_z, res, (q.size() > 0) ? q[0] : item_t'(0));
         else passed++;
         if (k == 0) begin
            checks++;
            if ({res, flag_n, flag_c} !== {16'hCDEF, 1'b1, 1'b0})
               $display("FAIL sweep_s0: got res=%h n%0b c%0b, need res=cdef n1 c0", res, flag_n, flag_c);
            else passed++;
         end
         if (k == 15) begin
            checks++;
            if ({res, flag_c} !== {16'h0001, 1'b1})
               $display("FAIL sweep_s15: got res=%h c%0b, need res=0001 c1", res, flag_c);
            else passed++;
         end
      end
      step(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
      checks++;
      if ({out_valid, out_count} !== {1'b0, 8'd16})
         $display("FAIL sweep_count: got v=%0b cnt=%0d, need v=0 cnt=16", out_valid, out_count);
      else passed++;
   endtask

   task automatic test_zero();
      step(1'b0, 1'b1, 4'd8, 16'h00FF, 1'b1);
      checks++;
      if ({out_valid, res, flag_z, flag_c, flag_n} !== {1'b1, 16'h0000, 1'b1, 1'b1, 1'b0})
         $display("FAIL zero_result: got v=%0b res=%h z%0b c%0b n%0b, need v=1 res=0000 z1 c1 n0",
                  out_valid, res, flag_z, flag_c, flag_n);
      else passed++;
      step(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
   endtask

   task automatic test_backpressure();
      logic [3:0]   sa, sb, sc;
      logic [W-1:0] da, db, dc;
      sa = 4'($urandom); sb = 4'($urandom); sc = 4'($urandom);
      da = 16'($urandom); db = 16'($urandom); dc = 16'($urandom);
      step(1'b1, 1'b0, 4'd0, 16'h0000, 1'b0);
      step(1'b0, 1'b1, sa, da, 1'b0);
      step(1'b0, 1'b1, sb, db, 1'b0);
      checks++;
      if ({in_ready, out_valid, flag_c, flag_n, flag_z, res} !== {1'b0, 1'b1, ref_item(sa, da)})
         $display("FAIL bp_full: got r=%0b v=%0b res=%h, need r=0 v=1 res=%h",
                  in_ready, out_valid, res, da >> sa);
      else passed++;
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, sc, dc, 1'b0);
         checks++;
         if ({in_ready, flag_c, flag_n, flag_z, res} !== {1'b0, ref_item(sa, da)})
            $display("FAIL bp_hold: got r=%0b res=%h, need r=0 res=%h", in_ready, res, da >> sa);
         else passed++;
      end
      step(1'b0, 1'b1, sc, dc, 1'b1);
      checks++;
      if ({in_ready, out_valid, flag_c, flag_n, flag_z, res} !== {1'b1, 1'b1, ref_item(sb, db)})
         $display("FAIL bp_second: got r=%0b v=%0b res=%h, need r=1 v=1 res=%h",
                  in_ready, out_valid, res, db >> sb);
      else passed++;
      step(1'b0, 1'b1, sc, dc, 1'b1);
      checks++;
      if ({out_valid, flag_c, flag_n, flag_z, res} !== {1'b1, ref_item(sc, dc)})
         $display("FAIL bp_third: got v=%0b res=%h, need v=1 res=%h", out_valid, res, dc >> sc);
      else passed++;
      step(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
      checks++;
      if ({out_valid, in_ready, out_count} !== {1'b0, 1'b1, 8'd3})
         $display("FAIL bp_drain: got v=%0b r=%0b cnt=%0d, need v=0 r=1 cnt=3",
                  out_valid, in_ready, out_count);
      else passed++;
   endtask

   task automatic test_reset_full();
      step(1'b0, 1'b1, 4'd1, 16'hAAAA, 1'b1);
      step(1'b0, 1'b1, 4'd2, 16'h5555, 1'b0);
      step(1'b0, 1'b1, 4'd3, 16'h9999, 1'b0);
      step(1'b1, 1'b1, 4'd4, 16'h7777, 1'b1);
      checks++;
      if ({out_valid, in_ready, out_count} !== {1'b0, 1'b1, 8'd0})
         $display("FAIL reset_full: got v=%0b r=%0b cnt=%0d, need v=0 r=1 cnt=0",
                  out_valid, in_ready, out_count);
      else passed++;
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
         checks++;
         if ({out_valid, out_count} !== {1'b0, 8'd0})
            $display("FAIL reset_full_stale: got v=%0b cnt=%0d, need v=0 cnt=0", out_valid, out_count);
         else passed++;
      end
   endtask

   task automatic test_random();
      step(1'b1, 1'b0, 4'd0, 16'h0000, 1'b0);
      for (int k = 0; k < 400; k++) begin
         step(1'b0, ($urandom % 4) != 0, 4'($urandom), 16'($urandom), ($urandom % 3) != 0);
         checks++;
         if ({out_valid, in_ready, out_count} !== {(q.size() > 0), (q.size() < 2), m_cnt})
            $display("FAIL random_ctrl cyc=%0d: got v=%0b r=%0b cnt=%0d, need v=%0b r=%0b cnt=%0d",
                     k, out_valid, in_ready, out_count, q.size() > 0, q.size() < 2, m_cnt);
         else passed++;
         if (q.size() > 0) begin
            checks++;
            if ({flag_c, flag_n, flag_z, res} !== q[0])
               $display("FAIL random_data cyc=%0d: got c%0b n%0b z%0b res=%h, need %h",
                        k, flag_c, flag_n, flag_z, res, q[0]);
            else passed++;
         end
      end
   endtask

   task automatic test_wrap();
      step(1'b1, 1'b0, 4'd0, 16'h0000, 1'b0);
      for (int k = 0; k < 257; k++) begin
         step(1'b0, 1'b1, 4'($urandom), 16'($urandom), 1'b1);
         checks++;
         if ({out_valid, in_ready, out_count, flag_c, flag_n, flag_z, res} !==
             {1'b1, 1'b1, m_cnt, q[0]})
            $display("FAIL wrap_stream cyc=%0d: got v=%0b r=%0b cnt=%0d res=%h, need v=1 r=1 cnt=%0d res=%h",
                     k, out_valid, in_ready, out_count, res, m_cnt, q[0][W-1:0]);
         else passed++;
      end
      checks++;
      if ({out_valid, out_count} !== {1'b1, 8'd0})
         $display("FAIL wrap_count: got v=%0b cnt=%0d, need v=1 cnt=0", out_valid, out_count);
      else passed++;
      step(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
      checks++;
      if ({out_valid, out_count} !== {1'b0, 8'd1})
         $display("FAIL wrap_drain: got v=%0b cnt=%0d, need v=0 cnt=1", out_valid, out_count);
      else passed++;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; s = '0; d_in = '0; d_out = '0; out_ready = 1'b0;
      test_reset();
      test_basic();
      test_sweep();
      test_zero();
      test_backpressure();
      test_reset_full();
      test_random();
      test_wrap();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
